miriscv_dmem_arb: RTL and testbench
===================================

MIRISCV_DMEM_ARB -- requirements
Module: miriscv_dmem_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the maximum BUSY cycles waited for mem_ready_i before abort; legal range 1..65535.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 arstn_i  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-004 m0_req_i / m1_req_i  input  1  request from port 0 (core LSU) / port 1 (DMA/debug).
REQ-005 m0_we_i / m1_we_i  input  1  write enable per port.
REQ-006 m0_be_i / m1_be_i  input  4  byte enables per port.
REQ-007 m0_addr_i / m1_addr_i  input  32  word address per port.
REQ-008 m0_wdata_i / m1_wdata_i  input  32  write data per port.
REQ-009 m0_rdata_o / m1_rdata_o  output  32  read data, valid only while the matching ready is high.
REQ-010 m0_ready_o / m1_ready_o  output  1  one-cycle completion pulse per port.
REQ-011 m0_err_o / m1_err_o  output  1  one-cycle error pulse, coincident with ready on timeout.
REQ-012 mem_req_o, mem_we_o  output  1  memory request / write enable.
REQ-013 mem_be_o  output  4; mem_addr_o, mem_wdata_o  output  32  memory byte enables, address, write data.
REQ-014 mem_rdata_i  input  32; mem_ready_i  input  1  memory read data and completion.

Function
REQ-015 FSM states: IDLE, BUSY0, BUSY1; one transaction is outstanding at most.
REQ-016 IDLE, only m0_req_i high -> BUSY0 next cycle; only m1_req_i high -> BUSY1.
REQ-017 IDLE, both high -> grant the port not equal to last_grant (round-robin); last_grant updates on every grant.
REQ-018 On grant, we/be/addr/wdata of the winner are registered; mem_* outputs are driven from these registers only.
REQ-019 mem_req_o = 1 exactly while in BUSY0/BUSY1; mem_we/be/addr/wdata = 0 in IDLE.
REQ-020 BUSYx with mem_ready_i = 1: mx_ready_o = 1 combinationally that cycle, mx_rdata_o = mem_rdata_i, FSM -> IDLE.
REQ-021 mx_rdata_o = 0 whenever mx_ready_o = 0; the non-granted port's ready/err/rdata stay 0.
REQ-022 Minimum latency: req seen in IDLE at cycle N, ready earliest at cycle N+1.
REQ-023 Requester drops req after ready is observed; req still high in IDLE the cycle after ready is a new request and is arbitrated (back-to-back allowed).
REQ-024 Deassertion of req during BUSYx is ignored; transaction completes and ready still pulses.
REQ-025 Input changes on the granted port during BUSYx do not affect mem_* outputs.
REQ-026 mem_ready_i while in IDLE is ignored.

Reset
REQ-027 arstn_i = 1 forces IDLE, last_grant = 1 (port 0 wins first tie), timeout counter = 0, immediately and asynchronously.
REQ-028 All outputs are 0 during reset; a transaction in flight at reset is dropped without ready or err pulses.
REQ-029 First grant is possible on the first rising edge after arstn_i deasserts.

Configuration
REQ-030 Macro DMEM_ARB_TIMEOUT_EN defined: a counter clears on entering BUSYx and increments each BUSY cycle without mem_ready_i.
REQ-031 With the macro, reaching TIMEOUT_CYCLES triggers abort: mx_ready_o = 1, mx_err_o = 1, mx_rdata_o = 0 that cycle, and FSM -> IDLE.
REQ-032 With the macro, mem_ready_i in the same cycle as the limit wins: normal completion, no err.
REQ-033 Macro undefined: no counter logic, m0_err_o = m1_err_o = 0 constant, BUSYx waits indefinitely.

Verification
REQ-034 m0 read addr 0x100, mem_ready_i on first BUSY cycle, mem_rdata_i=0xDEADBEEF -> m0_ready_o pulse at N+1, m0_rdata_o=0xDEADBEEF, m1 outputs 0.
REQ-035 m0 and m1 both request continuously for 4 transactions after reset -> grant order 0,1,0,1.
REQ-036 m1 write addr 0x20, be=0b0100, wdata=0x00AB0000, mem_ready_i delayed 3 cycles; m1 inputs changed mid-transaction -> mem_* hold original values for 3 cycles, then one m1_ready_o pulse.
REQ-037 With DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready_i held 0 -> m0_ready_o and m0_err_o pulse together at 4th BUSY cycle, rdata 0, FSM IDLE; without the macro, no pulse after 100 cycles.
REQ-038 arstn_i pulsed during BUSY0 -> mem_req_o 0 asynchronously, no ready pulse; next tie is granted to m0.

Source files
------------

// File: rtl/miriscv_dmem_arb.sv
// Two-port round-robin data-memory arbiter, one outstanding transaction.
// Optional busy-timeout abort enabled by defining DMEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction, arbitrate requests
// BUSY0 | port 0 transaction on the memory bus
// BUSY1 | port 1 transaction on the memory bus
module miriscv_dmem_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant0, grant1;
  logic        busy, timeout;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    case (state_q)
      IDLE: begin
        // port 0 wins a tie only when port 1 was granted last
        if (m0_req_i && (!m1_req_i || last_grant_q)) begin
          grant0       = 1'b1;
          state_d      = BUSY0;
          last_grant_d = 1'b0;
        end else if (m1_req_i) begin
          grant1       = 1'b1;
          state_d      = BUSY1;
          last_grant_d = 1'b1;
        end
      end
      BUSY0, BUSY1: if (mem_ready_i || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (grant0) begin
        we_q    <= m0_we_i;
        be_q    <= m0_be_i;
        addr_q  <= m0_addr_i;
        wdata_q <= m0_wdata_i;
      end else if (grant1) begin
        we_q    <= m1_we_i;
        be_q    <= m1_be_i;
        addr_q  <= m1_addr_i;
        wdata_q <= m1_wdata_i;
      end
    end
  end

`ifdef DMEM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  // count equals completed busy cycles, so the limit hits on the last allowed one
  assign timeout = busy && !mem_ready_i && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i)           to_cnt_q <= '0;
    else if (!busy)        to_cnt_q <= '0;
    else if (!mem_ready_i) to_cnt_q <= to_cnt_q + 16'd1;
  end

  assign m0_err_o = (state_q == BUSY0) && timeout;
  assign m1_err_o = (state_q == BUSY1) && timeout;
`else
  assign timeout  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  assign m0_ready_o = (state_q == BUSY0) && (mem_ready_i || timeout);
  assign m1_ready_o = (state_q == BUSY1) && (mem_ready_i || timeout);
  assign m0_rdata_o = ((state_q == BUSY0) && mem_ready_i) ? mem_rdata_i : '0;
  assign m1_rdata_o = ((state_q == BUSY1) && mem_ready_i) ? mem_rdata_i : '0;

  assign mem_req_o   = busy;
  assign mem_we_o    = busy && we_q;
  assign mem_be_o    = busy ? be_q    : '0;
  assign mem_addr_o  = busy ? addr_q  : '0;
  assign mem_wdata_o = busy ? wdata_q : '0;

endmodule

// File: tb/tb_miriscv_dmem_arb.sv
// Directed bench for miriscv_dmem_arb: vector table plus hand-written
// sequences for hold, reset-in-flight, round-robin and timeout behaviour.
module tb_miriscv_dmem_arb;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  miriscv_dmem_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  typedef struct {
    logic        m0_req; logic m0_we; logic [3:0] m0_be; logic [31:0] m0_addr; logic [31:0] m0_wdata;
    logic        m1_req; logic m1_we; logic [3:0] m1_be; logic [31:0] m1_addr; logic [31:0] m1_wdata;
    logic        mem_ready; logic [31:0] mem_rdata;
    logic        e_req; logic e_we; logic [3:0] e_be; logic [31:0] e_addr; logic [31:0] e_wdata;
    logic        e_rdy0; logic [31:0] e_rd0; logic e_rdy1; logic [31:0] e_rd1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    m0_req_i = 0; m0_we_i = 0; m0_be_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
    mem_ready_i = 0; mem_rdata_i = '0;
  endtask

  // advance to the sampling point of the next cycle's drive window
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req_o}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_rdy_err"}, {28'd0, m0_ready_o, m0_err_o, m1_ready_o, m1_err_o}, 32'd0);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{1,0,4'hF,32'h100,0, 0,0,0,0,0, 0,0,                   0,0,0,0,0, 0,0,0,0};
    vecs[1]  = '{0,0,4'hF,32'h100,0, 0,0,0,0,0, 1,32'hDEADBEEF,        1,0,4'hF,32'h100,0, 1,32'hDEADBEEF,0,0};
    vecs[2]  = '{0,0,0,0,0, 0,0,0,0,0, 1,32'h12345678,                 0,0,0,0,0, 0,0,0,0};
    vecs[3]  = '{1,1,4'h3,32'h10,32'hAAAA, 1,0,4'hF,32'h24,0, 0,0,     0,0,0,0,0, 0,0,0,0};
    vecs[4]  = '{1,1,4'h3,32'h10,32'hAAAA, 1,0,4'hF,32'h24,0, 0,0,     1,0,4'hF,32'h24,0, 0,0,0,0};
    vecs[5]  = '{1,1,4'h3,32'h10,32'hAAAA, 1,0,4'hF,32'h24,0, 1,32'h5555, 1,0,4'hF,32'h24,0, 0,0,1,32'h5555};
    vecs[6]  = '{1,1,4'h3,32'h10,32'hAAAA, 1,0,4'hF,32'h24,0, 0,0,     0,0,0,0,0, 0,0,0,0};
    vecs[7]  = '{1,1,4'h3,32'h10,32'hAAAA, 0,0,0,0,0, 1,32'h77,        1,1,4'h3,32'h10,32'hAAAA, 1,32'h77,0,0};
    vecs[8]  = '{1,1,4'h3,32'h10,32'hAAAA, 0,0,0,0,0, 0,0,             0,0,0,0,0, 0,0,0,0};
    vecs[9]  = '{0,0,4'hC,32'h999,32'hBBBB, 0,0,0,0,0, 0,0,            1,1,4'h3,32'h10,32'hAAAA, 0,0,0,0};
    vecs[10] = '{0,0,4'hC,32'h999,32'hBBBB, 0,0,0,0,0, 1,32'hCAFE0000, 1,1,4'h3,32'h10,32'hAAAA, 1,32'hCAFE0000,0,0};
    vecs[11] = '{0,0,0,0,0, 0,0,0,0,0, 0,0,                            0,0,0,0,0, 0,0,0,0};

    // reset: outputs must be 0 even with memory signalling completion
    clr_in();
    arstn_i = 1;
    mem_ready_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    #3;
    chk_idle_outs("reset");
    chk("reset_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    cyc(); cyc();
    arstn_i = 0;
    clr_in();

    for (int i = 0; i < 12; i++) begin
      cyc();
      m0_req_i = vecs[i].m0_req; m0_we_i = vecs[i].m0_we; m0_be_i = vecs[i].m0_be;
      m0_addr_i = vecs[i].m0_addr; m0_wdata_i = vecs[i].m0_wdata;
      m1_req_i = vecs[i].m1_req; m1_we_i = vecs[i].m1_we; m1_be_i = vecs[i].m1_be;
      m1_addr_i = vecs[i].m1_addr; m1_wdata_i = vecs[i].m1_wdata;
      mem_ready_i = vecs[i].mem_ready; mem_rdata_i = vecs[i].mem_rdata;
      #3;
      chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req_o}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we_o}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_mem_be", i), {28'd0, mem_be_o}, {28'd0, vecs[i].e_be});
      chk($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].e_wdata);
      chk($sformatf("v%0d_m0_ready", i), {31'd0, m0_ready_o}, {31'd0, vecs[i].e_rdy0});
      chk($sformatf("v%0d_m0_rdata", i), m0_rdata_o, vecs[i].e_rd0);
      chk($sformatf("v%0d_m1_ready", i), {31'd0, m1_ready_o}, {31'd0, vecs[i].e_rdy1});
      chk($sformatf("v%0d_m1_rdata", i), m1_rdata_o, vecs[i].e_rd1);
      chk($sformatf("v%0d_err", i), {30'd0, m0_err_o, m1_err_o}, 32'd0);
    end

    // m1 write with delayed ready; its inputs change while busy
    cyc();
    clr_in();
    m1_req_i = 1; m1_we_i = 1; m1_be_i = 4'b0100; m1_addr_i = 32'h20; m1_wdata_i = 32'h00AB_0000;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      m1_req_i = 0; m1_we_i = 0; m1_be_i = 4'hF; m1_addr_i = 32'h44 + k; m1_wdata_i = 32'hFFFF;
      mem_ready_i = (k == 4); mem_rdata_i = 32'h0BAD_0000;
      #3;
      chk($sformatf("hold%0d_we_be", k), {27'd0, mem_req_o, mem_we_o, mem_be_o}, {27'd0, 1'b1, 1'b1, 4'b0100});
      chk($sformatf("hold%0d_addr", k), mem_addr_o, 32'h20);
      chk($sformatf("hold%0d_wdata", k), mem_wdata_o, 32'h00AB_0000);
      chk($sformatf("hold%0d_ready", k), {30'd0, m0_ready_o, m1_ready_o}, {30'd0, 1'b0, k == 4});
    end
    cyc();
    clr_in();
    #3;
    chk_idle_outs("after_hold");

    // reset pulse while m0 is in flight
    cyc();
    m0_req_i = 1; m0_addr_i = 32'h300;
    cyc();
    m0_req_i = 0;
    #1;
    chk("pre_rst_busy", {31'd0, mem_req_o}, 32'd1);
    #1;
    arstn_i = 1;
    mem_ready_i = 1; mem_rdata_i = 32'h1111_2222;
    #1;
    chk("rst_busy_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_busy_ready", {30'd0, m0_ready_o, m0_err_o}, 32'd0);
    cyc();
    #2;
    arstn_i = 0;
    clr_in();

    // both ports request continuously: expect grants 0,1,0,1
    cyc();
    m0_req_i = 1; m0_addr_i = 32'h310; m1_req_i = 1; m1_addr_i = 32'h320;
    mem_ready_i = 1; mem_rdata_i = 32'h0000_00AA;
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("rr%0d_m0_ready", i), {31'd0, m0_ready_o}, {31'd0, (i % 4) == 1});
      chk($sformatf("rr%0d_m1_ready", i), {31'd0, m1_ready_o}, {31'd0, (i % 4) == 3});
      chk($sformatf("rr%0d_addr", i), mem_addr_o,
          ((i % 4) == 1) ? 32'h310 : (((i % 4) == 3) ? 32'h320 : 32'h0));
      if (i < 7) cyc();
    end
    cyc();
    clr_in();
    cyc();

    // memory never answers
    m0_req_i = 1; m0_addr_i = 32'h400;
`ifdef DMEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      cyc();
      m0_req_i = 0; mem_ready_i = 0; mem_rdata_i = 32'hFFFF_FFFF;
      #3;
      chk($sformatf("to%0d_rdy_err", k), {30'd0, m0_ready_o, m0_err_o}, (k == 4) ? 32'd3 : 32'd0);
      chk($sformatf("to%0d_rdata", k), m0_rdata_o, 32'd0);
      chk($sformatf("to%0d_m1", k), {30'd0, m1_ready_o, m1_err_o}, 32'd0);
    end
    cyc();
    #3;
    chk("to_idle_mem_req", {31'd0, mem_req_o}, 32'd0);
    cyc();
    // ready arriving on the limit cycle completes normally
    m0_req_i = 1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      m0_req_i = 0; mem_ready_i = (k == 4); mem_rdata_i = 32'h1234;
      #3;
      chk($sformatf("tolim%0d_rdy_err", k), {30'd0, m0_ready_o, m0_err_o}, (k == 4) ? 32'd2 : 32'd0);
    end
    chk("tolim_rdata", m0_rdata_o, 32'h1234);
`else
    pulses = 0;
    for (int k = 1; k <= 100; k++) begin
      cyc();
      m0_req_i = 0; mem_ready_i = 0;
      #3;
      if (m0_ready_o || m0_err_o || m1_ready_o || m1_err_o || !mem_req_o) pulses++;
    end
    chk("no_timeout_pulses", pulses, 32'd0);
    cyc();
    mem_ready_i = 1; mem_rdata_i = 32'h5A5A;
    #3;
    chk("late_ready_rdy_err", {30'd0, m0_ready_o, m0_err_o}, 32'd2);
    chk("late_ready_rdata", m0_rdata_o, 32'h5A5A);
`endif
    cyc();
    clr_in();
    #3;
    chk_idle_outs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
